fpu_req_arbiter: RTL and testbench
==================================

// Module: fpu_req_arbiter
// PURPOSE
// - Shares one FPU core (add/sub/mul/square/div/sqrt/sin/cos/tan/ln/exp) between NUM_REQ requesters.
// - Round-robin arbitration; one operation in flight.
// - Issues start to the FPU, captures its result, returns it to the granted requester with a valid/ack handshake.
// - Sits between the CPU bus-side FPU register port(s) and the FPU arithmetic core.
// PARAMETERS
// - NUM_REQ     2    number of requesters (2..8)
// - DATA_W      32   operand/result width (IEEE-754 single)
// - TIMEOUT_CYC 1024 watchdog limit in cycles; used only with FPU_ARB_TIMEOUT_EN
// PORTS
// - clk          in   1               single clock, all logic on rising edge
// - rst          in   1               synchronous, active-high reset
// - req_valid    in   NUM_REQ         per-requester request, held until req_ready
// - req_op       in   NUM_REQ*4       per-requester opcode: 0 add, 1 sub, 2 mul, 3 square, 4 div, 5 sqrt, 6 sin, 7 cos, 8 tan, 9 ln, A exp
// - req_a        in   NUM_REQ*DATA_W  per-requester operand A
// - req_b        in   NUM_REQ*DATA_W  per-requester operand B
// - req_ready    out  NUM_REQ         one-cycle accept pulse to the granted requester
// - rsp_valid    out  NUM_REQ         result valid for the owner, held until rsp_ack
// - rsp_result   out  DATA_W          result, shared bus, valid while any rsp_valid
// - rsp_err      out  1               qualifies rsp_result: 1 = illegal opcode (or timeout)
// - rsp_ack      in   NUM_REQ         owner acknowledges result
// - fpu_start    out  1               one-cycle start pulse to the FPU core
// - fpu_op       out  4               latched opcode
// - fpu_a        out  DATA_W          latched operand A
// - fpu_b        out  DATA_W          latched operand B
// - fpu_done     in   1               FPU result ready, level, held until fpu_ack
// - fpu_result   in   DATA_W          FPU result, valid while fpu_done
// - fpu_ack      out  1               one-cycle ack; FPU drops fpu_done next cycle
// - busy         out  1               high in every state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0; all outputs 0 (req_ready, rsp_valid, rsp_result, rsp_err, fpu_start, fpu_op, fpu_a, fpu_b, fpu_ack, busy).
// - Reset has priority over everything. Reset mid-operation drops the transaction silently; any late fpu_done is ignored until the next ISSUE.
// - States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// - IDLE: on any req_valid, grant g = first set bit at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
//   - Latch op/a/b of g into fpu_op/fpu_a/fpu_b; pulse req_ready[g].
//   - Opcode > 4'hA: skip the FPU, go to RESP with rsp_result=0, rsp_err=1.
//   - Otherwise go to ISSUE.
// - ISSUE: fpu_start=1 for exactly one cycle -> WAIT.
// - WAIT: when fpu_done=1, capture fpu_result into rsp_result, pulse fpu_ack in the same cycle, rsp_err=0 -> RESP.
// - RESP: rsp_valid[g]=1, held with rsp_result stable. On rsp_ack[g]: rsp_valid cleared next cycle, rr_ptr=(g+1) mod NUM_REQ -> IDLE.
//   - rsp_ack on any bit other than g is ignored.
// - Latency: accept at cycle 0, fpu_start at cycle 1, fpu_done at cycle k, rsp_valid from k+1. Min request-to-result = 3 cycles.
// - Fairness: a requester holding req_valid is granted within NUM_REQ transactions.
// - Requests arriving while busy wait; req_valid must stay high until req_ready.
// - A requester may reassert req_valid during its own RESP. The new request is granted only after the pointer advances.
// - fpu_done seen outside WAIT is ignored; no fpu_ack is issued.
// - At most one bit of req_ready/rsp_valid is set at any time.
// CONFIGURATION
// - FPU_ARB_TIMEOUT_EN defined: 16-bit counter cleared on ISSUE, counting in WAIT.
//   - Reaching TIMEOUT_CYC without fpu_done: go to RESP with rsp_err=1, rsp_result=32'h7FC00000 (qNaN); no fpu_ack issued.
// - FPU_ARB_TIMEOUT_EN undefined: no counter; WAIT waits on fpu_done indefinitely.
// TESTING
// - After reset, no stimulus -> all outputs 0, busy=0 for 10 cycles.
// - Req0 op=0, a=3F800000, b=40000000; FPU model done after 5 cycles with 40400000
//   -> req_ready[0] at c0, fpu_start at c1, fpu_ack at c6, rsp_valid[0] with 40400000 at c7.
// - Both req_valid held, each acks immediately, 4 transactions -> grant order 0,1,0,1; never two grants in a row to one requester.
// - Req1 op=4'hC -> req_ready[1], no fpu_start, rsp_valid[1] with rsp_err=1, rsp_result=0.
// - Reset asserted in WAIT, then fpu_done pulsed -> no fpu_ack, no rsp_valid, state IDLE.
// - FPU_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, fpu_done never asserted
//   -> rsp_valid with err=1, result 7FC00000, 17 cycles after fpu_start.

Source files
------------

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one FPU core between NUM_REQ requesters, one operation in flight.
// Optional WAIT-state watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_req_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*4-1:0]      req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_err,
    input  logic [NUM_REQ-1:0]        rsp_ack,
    output logic                      fpu_start,
    output logic [3:0]                fpu_op,
    output logic [DATA_W-1:0]         fpu_a,
    output logic [DATA_W-1:0]         fpu_b,
    input  logic                      fpu_done,
    input  logic [DATA_W-1:0]         fpu_result,
    output logic                      fpu_ack,
    output logic                      busy
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned OP_W   = 4;
    localparam logic [3:0]  OP_MAX = 4'hA;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("fpu_req_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("fpu_req_arbiter: TIMEOUT_CYC must fit the 16-bit watchdog");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_err_q, rsp_err_d;
    logic                fpu_start_q, fpu_start_d;
    logic [OP_W-1:0]     fpu_op_q, fpu_op_d;
    logic [DATA_W-1:0]   fpu_a_q, fpu_a_d;
    logic [DATA_W-1:0]   fpu_b_q, fpu_b_d;
    logic                busy_q, busy_d;

    logic                pick_found;
    logic [PTR_W-1:0]    pick_idx;
    int unsigned         cand;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [NUM_REQ-1:0]  gnt_oh;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam logic [15:0]       TMO_LIMIT = 16'(TIMEOUT_CYC);
    localparam logic [DATA_W-1:0] QNAN      = DATA_W'(32'h7FC0_0000);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(rr_ptr_q) + off) % NUM_REQ;
            if (!pick_found && req_valid[PTR_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(cand);
            end
        end
    end

    // Operand mux for the picked requester.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == pick_idx) begin
                sel_op = req_op[i*OP_W +: OP_W];
                sel_a  = req_a[i*DATA_W +: DATA_W];
                sel_b  = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign pick_oh = NUM_REQ'(1) << pick_idx;
    assign gnt_oh  = NUM_REQ'(1) << gnt_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        req_ready_d  = '0;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        fpu_start_d  = 1'b0;
        fpu_op_d     = fpu_op_q;
        fpu_a_d      = fpu_a_q;
        fpu_b_d      = fpu_b_q;
`ifdef FPU_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_d       = pick_idx;
                    req_ready_d = pick_oh;
                    fpu_op_d    = sel_op;
                    fpu_a_d     = sel_a;
                    fpu_b_d     = sel_b;
                    if (sel_op > OP_MAX) begin
                        // Illegal opcode bypasses the core entirely.
                        rsp_valid_d  = pick_oh;
                        rsp_result_d = '0;
                        rsp_err_d    = 1'b1;
                        state_d      = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                fpu_start_d = 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
                tmo_cnt_d   = '0;
`endif
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (fpu_done) begin
                    rsp_valid_d  = gnt_oh;
                    rsp_result_d = fpu_result;
                    rsp_err_d    = 1'b0;
                    state_d      = S_RESP;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (tmo_cnt_q >= TMO_LIMIT) begin
                    rsp_valid_d  = gnt_oh;
                    rsp_result_d = QNAN;
                    rsp_err_d    = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ack[gnt_q]) begin
                    rsp_valid_d = '0;
                    rr_ptr_d    = (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            fpu_start_q  <= 1'b0;
            fpu_op_q     <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            busy_q       <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            fpu_start_q  <= fpu_start_d;
            fpu_op_q     <= fpu_op_d;
            fpu_a_q      <= fpu_a_d;
            fpu_b_q      <= fpu_b_d;
            busy_q       <= busy_d;
`ifdef FPU_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    // Ack answers fpu_done in the same cycle, so it cannot be registered.
    assign fpu_ack    = !rst && (state_q == S_WAIT) && fpu_done;

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign fpu_start  = fpu_start_q;
    assign fpu_op     = fpu_op_q;
    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Bench for fpu_req_arbiter: vector table through a scoreboard, plus round-robin, reset and timeout sequences.
module tb_fpu_req_arbiter;

    localparam int unsigned NR  = 2;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NR-1:0]        req_valid = '0;
    logic [NR*4-1:0]      req_op = '0;
    logic [NR*DW-1:0]     req_a = '0;
    logic [NR*DW-1:0]     req_b = '0;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0]        rsp_valid;
    logic [DW-1:0]        rsp_result;
    logic                 rsp_err;
    logic [NR-1:0]        rsp_ack = '0;
    logic                 fpu_start;
    logic [3:0]           fpu_op;
    logic [DW-1:0]        fpu_a;
    logic [DW-1:0]        fpu_b;
    logic                 fpu_done;
    logic [DW-1:0]        fpu_result = '0;
    logic                 fpu_ack;
    logic                 busy;

    fpu_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .rsp_ack(rsp_ack),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_ack(fpu_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned req;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int unsigned lat;
        bit          tmo;
    } vec_t;

    typedef struct {
        int unsigned req;
        logic [31:0] result;
        logic        err;
        int unsigned lat_exp;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ack_cnt = 0;
    bit          ack_seen = 1'b0;
    int unsigned exp_ptr = 0;

    // Behavioural FPU core: done lat_cfg cycles after the start cycle, dropped after ack.
    int unsigned lat_cfg = 1;
    int unsigned cd = 0;
    bit          model_done = 1'b0;
    bit          manual_done = 1'b0;
    assign fpu_done = model_done | manual_done;

    always @(posedge clk) begin
        cyc = cyc + 1;
        ack_seen = fpu_ack;
        if (fpu_ack) ack_cnt = ack_cnt + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            cd = 0;
            model_done = 1'b0;
        end else begin
            if (model_done && ack_seen) model_done = 1'b0;
            if (fpu_start) begin
                cd = lat_cfg;
            end else if (cd != 0) begin
                cd = cd - 1;
                if (cd == 0) model_done = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int unsigned i);
        logic [NR-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        exp_t        e;
        bit          legal;
        bit          got;
        int          ready_cyc;
        int          start_cyc;
        int          starts;
        int          ack0;
        legal     = (v.op <= 4'hA);
        e.req     = v.req;
        e.err     = !legal || v.tmo;
        e.result  = !legal ? 32'h0 : (v.tmo ? 32'h7FC0_0000 : v.res);
        e.lat_exp = !legal ? 0 : (v.tmo ? TMO + 2 : v.lat + 2);
        sb_q.push_back(e);
        lat_cfg    = v.tmo ? 0 : v.lat;
        fpu_result = v.res;
        req_op[v.req*4 +: 4]  = v.op;
        req_a[v.req*DW +: DW] = v.a;
        req_b[v.req*DW +: DW] = v.b;
        req_valid[v.req]      = 1'b1;
        ack0 = ack_cnt;
        got  = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin got = 1'b1; break; end
        end
        chk("req_ready", 128'(req_ready), 128'(onehot(v.req)));
        ready_cyc = cyc;
        req_valid[v.req] = 1'b0;
        starts = 0;
        start_cyc = 0;
        got = 1'b0;
        for (int n = 0; n < int'(TMO) + 60; n++) begin
            if (fpu_start) begin
                starts = starts + 1;
                start_cyc = cyc;
                chk("fpu_op", 128'(fpu_op), 128'(v.op));
                chk("fpu_a", 128'(fpu_a), 128'(v.a));
                chk("fpu_b", 128'(fpu_b), 128'(v.b));
            end
            if (rsp_valid != '0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("rsp_seen", 128'(got), 128'(1));
        e = sb_q.pop_front();
        chk("rsp_valid", 128'(rsp_valid), 128'(onehot(e.req)));
        chk("rsp_result", 128'(rsp_result), 128'(e.result));
        chk("rsp_err", 128'(rsp_err), 128'(e.err));
        chk("rsp_latency", 128'(cyc - ready_cyc), 128'(e.lat_exp));
        chk("start_count", 128'(starts), 128'(legal ? 1 : 0));
        if (legal) chk("start_cycle", 128'(start_cyc - ready_cyc), 128'(1));
        chk("fpu_ack_count", 128'(ack_cnt - ack0), 128'((legal && !v.tmo) ? 1 : 0));
        // Ack on the wrong bit must not release the response.
        rsp_ack = ~onehot(v.req);
        @(negedge clk);
        rsp_ack = '0;
        @(negedge clk);
        chk("rsp_hold", 128'(rsp_valid), 128'(onehot(e.req)));
        chk("rsp_stable", 128'(rsp_result), 128'(e.result));
        rsp_ack = onehot(v.req);
        @(negedge clk);
        rsp_ack = '0;
        chk("rsp_clear", 128'(rsp_valid), 128'(0));
        chk("busy_idle", 128'(busy), 128'(0));
        exp_ptr = (v.req + 1) % NR;
    endtask

    task automatic rr_test();
        int unsigned expg;
        int          g;
        int          prev;
        bit          got;
        expg = exp_ptr;
        prev = -1;
        lat_cfg = 1;
        fpu_result = 32'h4120_0000;
        req_op = {4'h2, 4'h1};
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (req_ready != '0) begin got = 1'b1; break; end
            end
            chk("rr_ready_seen", 128'(got), 128'(1));
            g = req_ready[1] ? 1 : 0;
            chk("rr_grant", 128'(req_ready), 128'(onehot(expg)));
            chk("rr_no_repeat", 128'(g == prev), 128'(0));
            got = 1'b0;
            for (int n = 0; n < 50; n++) begin
                if (rsp_valid != '0) begin got = 1'b1; break; end
                @(negedge clk);
            end
            chk("rr_rsp_valid", 128'(rsp_valid), 128'(onehot(expg)));
            chk("rr_rsp_result", 128'(rsp_result), 128'(32'h4120_0000));
            rsp_ack = onehot(expg);
            @(negedge clk);
            rsp_ack = '0;
            if (k == 3) req_valid = '0;
            prev = g;
            expg = (expg + 1) % NR;
        end
        exp_ptr = expg;
        @(negedge clk);
        chk("rr_end_idle", 128'(busy), 128'(0));
    endtask

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 4'h0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5, 1'b0};
        vecs[1] = '{1, 4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 32'hDEAD_BEEF, 3, 1'b0};
        vecs[2] = '{1, 4'h2, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 1, 1'b0};
        vecs[3] = '{0, 4'hA, 32'h3F80_0000, 32'h0000_0000, 32'h402D_F854, 3, 1'b0};
        vecs[4] = '{1, 4'hB, 32'h0000_0001, 32'h0000_0002, 32'h5555_5555, 2, 1'b0};
        vecs[5] = '{0, 4'h5, 32'h4080_0000, 32'h0000_0000, 32'h4000_0000, 2, 1'b0};
        vecs[6] = '{1, 4'hF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ctrl", 128'({req_ready, rsp_valid, rsp_err, fpu_start, fpu_ack, busy, fpu_op}), 128'(0));
            chk("idle_data", {32'h0, rsp_result, fpu_a, fpu_b}, 128'(0));
        end

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        rr_test();

        // Reset in WAIT, then a late fpu_done must be ignored.
        lat_cfg = 0;
        req_op[3:0] = 4'h2;
        req_valid[0] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready != '0) break;
        end
        req_valid[0] = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (fpu_start) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("wait_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        manual_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_done_ack", 128'(fpu_ack), 128'(0));
            chk("late_done_rsp", 128'(rsp_valid), 128'(0));
            chk("late_done_busy", 128'(busy), 128'(0));
        end
        manual_done = 1'b0;
        exp_ptr = 0;
        @(negedge clk);

        rr_test();

`ifdef FPU_ARB_TIMEOUT_EN
        run_txn('{0, 4'h6, 32'h3F80_0000, 32'h0, 32'h1111_1111, 0, 1'b1});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
